axis_edge_unpad_packer: RTL
===========================

Name: axis_edge_unpad_packer

Overview:
- Output-side counterpart of the maxpool engine's edge-padded AXI-Stream.
- Accepts one wide beat of 2*GROUPS*UNITS_EDGES words with per-word tkeep and discards the zero edge units.
- Compacts the kept interior words in order and re-emits them as a narrow OUT_WORDS-wide stream toward the output DMA.
- Preserves tlast and honours full AXIS backpressure on both sides.

Parameters:
- WORD_WIDTH, 8: bits per word.
- GROUPS, 2: groups per channel half.
- UNITS, 4: interior units per group.
- KH_MAX, 3: odd max kernel height. Edge pad P = KH_MAX/2 on each side.
- UNITS_EDGES, UNITS+2*(KH_MAX/2): units per group including edges (derived).
- OUT_WORDS, 4: words per output beat. Must divide 2*GROUPS*UNITS.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat ready.
- s_axis_tdata  in  2*GROUPS*UNITS_EDGES*WORD_WIDTH  word at flat index c*GROUPS*UNITS_EDGES + g*UNITS_EDGES + u.
- s_axis_tkeep  in  2*GROUPS*UNITS_EDGES  per-word keep, same indexing.
- s_axis_tlast  in  1  end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  OUT_WORDS*WORD_WIDTH  packed words; word 0 in LSBs.
- m_axis_tkeep  out  OUT_WORDS  per-word valid.
- m_axis_tlast  out  1  end of packet.

Behaviour:
- Reset: aclk domain only; areset is synchronous and active-high.
  - State goes to IDLE; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, beat counter=0.
  - s_axis_tready=0 while areset is high.
- States: IDLE and SEND.
  - IDLE: s_axis_tready=1.
  - SEND: s_axis_tready=1 only when the current beat is the final beat and m_axis_tready=1. This gives zero-bubble back-to-back operation.
- Accept (s_valid & s_ready):
  - A word at unit u survives only if P <= u < P+UNITS and its keep bit is 1. Edge words are dropped regardless of keep or data.
  - Survivors are compacted in ascending flat order into buffer buf[0..2*GROUPS*UNITS-1].
  - Register count K (0..2*GROUPS*UNITS), NB = ceil(K/OUT_WORDS), and the tlast flag.
  - Buffer words at or above K are zeroed.
- Beat generation after accept:
  - If NB>0: go to SEND; beat b presents buf[b*OUT_WORDS +: OUT_WORDS] with m_axis_tvalid=1 on the cycle after accept (latency 1).
  - tkeep bit j = (b*OUT_WORDS+j < K).
  - tlast = stored tlast and (b==NB-1).
- Empty beat:
  - If K=0 and tlast=1: emit exactly one beat with tkeep=0, tdata=0, tlast=1.
  - If K=0 and tlast=0: emit nothing; stay or return to IDLE with tvalid=0.
- Output handshake:
  - Advance b on m_valid & m_ready. tdata, tkeep and tlast are held stable while tvalid=1 and tready=0.
  - On the final-beat handshake:
    - with a simultaneous accept: load the new beat and continue.
    - otherwise: go to IDLE, tvalid=0.
- No packing across input beats: each input beat starts at output word 0.
- Reset mid-SEND: remaining words are discarded; outputs take reset values on the next edge.
- Widths:
  - K is clog2(2*GROUPS*UNITS+1) bits.
  - The beat counter is clog2(2*GROUPS*UNITS/OUT_WORDS+1) bits.

Decomposition:
- Shared package holds WORD_WIDTH, GROUPS, UNITS, KH_MAX, UNITS_EDGES, P and derived S_WORDS / I_WORDS constants. It is shared with the maxpool engine.
- One natural sub-module: word_compactor, purely combinational.
  - Function: mask edges, prefix-sum the keep bits, scatter survivors and produce K.
- The top level holds the FSM, buffer registers and beat counter.

Test Plan (GROUPS=2, UNITS=4, KH_MAX=3, OUT_WORDS=4 → 24 in-words, 16 interior):
1. All keep=1, interior data = 0..15 in order, edge data=0xFF, tlast=1, m_ready=1.
   → 4 beats carrying words 0-3, 4-7, 8-11, 12-15; tkeep=4'b1111 on each; tlast only on beat 4; 0xFF never appears.
2. Keep set only on c=0 words (flat 0..11).
   → K=8 → 2 full beats, then IDLE.
3. Keep set on 5 interior words with values 10,20,30,40,50.
   → beat1 = {40,30,20,10}; beat2 = {0,0,0,50}, tkeep=4'b0001.
4. All keep=0 with tlast=1.
   → one beat with tkeep=0, tlast=1. All keep=0 with tlast=0 → no output; s_ready stays 1.
5. Random m_ready (50%) plus two back-to-back input beats.
   → data held stable under stall; second beat accepted in the same cycle as the first beat's final handshake; order preserved.
6. Assert areset during beat 2 of 4.
   → next cycle tvalid=0, s_ready=0; after release, IDLE with s_ready=1 and no residual beats.

Source files
------------

// File: rtl/axis_edge_unpad_packer_pkg.sv
// Geometry shared by the maxpool engine and its edge-unpad output packer.
// Defines the padded/interior word counts and the edge-unit test.
package axis_edge_unpad_packer_pkg;

    localparam int WORD_WIDTH  = 8;
    localparam int GROUPS      = 2;
    localparam int UNITS       = 4;
    localparam int KH_MAX      = 3;
    localparam int P           = KH_MAX / 2;
    localparam int UNITS_EDGES = UNITS + 2 * P;
    localparam int S_WORDS     = 2 * GROUPS * UNITS_EDGES;
    localparam int I_WORDS     = 2 * GROUPS * UNITS;
    localparam int K_WIDTH     = $clog2(I_WORDS + 1);

    // Edge units carry zero padding only; flat index wraps every UNITS_EDGES words.
    function automatic logic is_interior(input int flat);
        int u;
        u = flat % UNITS_EDGES;
        return (u >= P) && (u < P + UNITS);
    endfunction

endpackage

// File: rtl/axis_edge_unpad_packer_word_compactor.sv
// Combinational compaction of one padded beat: drops edge words and
// unkept words, packs the survivors from word 0 upward and counts them.
module axis_edge_unpad_packer_word_compactor
    import axis_edge_unpad_packer_pkg::*;
(
    input  logic [S_WORDS*WORD_WIDTH-1:0] data,
    input  logic [S_WORDS-1:0]            keep,
    output logic [I_WORDS*WORD_WIDTH-1:0] packed_data,
    output logic [K_WIDTH-1:0]            count
);

    // The running survivor count is the prefix sum that picks each destination slot.
    always_comb begin
        int n;
        packed_data = '0;
        n = 0;
        for (int i = 0; i < S_WORDS; i++) begin
            if (keep[i] && is_interior(i)) begin
                packed_data[n*WORD_WIDTH +: WORD_WIDTH] = data[i*WORD_WIDTH +: WORD_WIDTH];
                n++;
            end
        end
        count = K_WIDTH'(n);
    end

endmodule

// File: rtl/axis_edge_unpad_packer.sv
// Strips edge padding from a wide AXIS beat and re-emits the interior words
// as a narrow OUT_WORDS-wide stream, one input beat per output packet segment.
module axis_edge_unpad_packer
    import axis_edge_unpad_packer_pkg::*;
#(
    parameter int OUT_WORDS = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [S_WORDS*WORD_WIDTH-1:0] s_axis_tdata,
    input  logic [S_WORDS-1:0]            s_axis_tkeep,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [OUT_WORDS*WORD_WIDTH-1:0] m_axis_tdata,
    output logic [OUT_WORDS-1:0]          m_axis_tkeep,
    output logic                          m_axis_tlast
);

    localparam int BEATS_MAX = I_WORDS / OUT_WORDS;
    localparam int BW        = $clog2(BEATS_MAX + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]                    state;
    logic [I_WORDS*WORD_WIDTH-1:0] buffer;
    logic [K_WIDTH-1:0]            k_q;
    logic [BW-1:0]                 nb_q;
    logic [BW-1:0]                 beat_q;
    logic                          last_q;

    logic [I_WORDS*WORD_WIDTH-1:0] comp_data;
    logic [K_WIDTH-1:0]            comp_count;
    logic [BW-1:0]                 nb_new;
    logic                          final_beat;
    logic                          accept;
    logic                          out_hs;

    axis_edge_unpad_packer_word_compactor u_compactor (
        .data        (s_axis_tdata),
        .keep        (s_axis_tkeep),
        .packed_data (comp_data),
        .count       (comp_count)
    );

    // An empty beat still owes one tkeep=0 beat downstream if it closes a packet.
    always_comb begin
        nb_new = '0;
        if (comp_count == '0)
            nb_new = s_axis_tlast ? BW'(1) : BW'(0);
        else
            nb_new = BW'((int'(comp_count) + OUT_WORDS - 1) / OUT_WORDS);
    end

    assign final_beat    = (beat_q == nb_q - 1'b1);
    assign m_axis_tvalid = (state == SEND);
    assign s_axis_tready = !areset && ((state == IDLE) || (final_beat && m_axis_tready));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign out_hs        = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= IDLE;
            buffer <= '0;
            k_q    <= '0;
            nb_q   <= '0;
            beat_q <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            buffer <= comp_data;
            k_q    <= comp_count;
            nb_q   <= nb_new;
            beat_q <= '0;
            last_q <= s_axis_tlast;
            state  <= (nb_new != '0) ? SEND : IDLE;
        end else if (out_hs) begin
            if (final_beat)
                state <= IDLE;
            else
                beat_q <= beat_q + 1'b1;
        end
    end

    assign m_axis_tdata = buffer[int'(beat_q)*OUT_WORDS*WORD_WIDTH +: OUT_WORDS*WORD_WIDTH];
    assign m_axis_tlast = last_q && final_beat;

    always_comb begin
        m_axis_tkeep = '0;
        for (int j = 0; j < OUT_WORDS; j++)
            m_axis_tkeep[j] = (int'(beat_q) * OUT_WORDS + j) < int'(k_q);
    end

endmodule
